// File: rtl/mov_wide_pkg.sv
// -----------------------------------------------------------------------------
// mov_wide_pkg
// Shared definitions for the wide-move (MOVZ/MOVN/MOVK) instruction-word
// decoder. It holds the sequencer state encoding, the opcode constants with sf
// stripped, and the ALU/PC function-select codes. It also holds the bit offsets
// of the 33-bit control word, which every IW decoder in the control unit shares.
//
// Control word layout (bit 32 is reserved and always 0):
//   [31] alu_en  [30] alu_bs  [29:25] alu_fs  [24] rf_b_en  [23:19] rf_sa
//   [18:14] rf_sb  [13:9] rf_da  [8] rf_w  [7] ram_en  [6] ram_w
//   [5:4] pc_fs  [3] pc_is  [2] status_ld  [1:0] next_state
// -----------------------------------------------------------------------------
package mov_wide_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MASK = 2'd1,
      ST_EXEC = 2'd2,
      ST_ERR  = 2'd3
   } state_t;

   // Instruction word without the sf bit: {op[7:0], hw[1:0], imm[15:0], Rd[4:0]}.
   typedef struct packed {
      logic [7:0]  op;
      logic [1:0]  hw;
      logic [15:0] imm;
      logic [4:0]  rd;
   } mov_fields_t;

   localparam logic [7:0] OP_MOVZ = 8'b1010_0101;
   localparam logic [7:0] OP_MOVN = 8'b0010_0101;
   localparam logic [7:0] OP_MOVK = 8'b1110_0101;

   localparam logic [4:0] FS_AND   = 5'b00000;  // A & B
   localparam logic [4:0] FS_OR    = 5'b00100;  // A | B
   localparam logic [4:0] FS_OR_NB = 5'b00110;  // A | ~B

   localparam logic [1:0] PC_HOLD = 2'b00;
   localparam logic [1:0] PC_INC4 = 2'b01;

   // next_state field: 01 = another micro-op follows, 00 = instruction ends.
   localparam logic [1:0] NS_DONE = 2'b00;
   localparam logic [1:0] NS_CONT = 2'b01;

   localparam int CW_WIDTH      = 33;
   localparam int CW_ALU_EN     = 31;
   localparam int CW_ALU_BS     = 30;
   localparam int CW_ALU_FS     = 25;
   localparam int CW_RF_B_EN    = 24;
   localparam int CW_RF_SA      = 19;
   localparam int CW_RF_SB      = 14;
   localparam int CW_RF_DA      = 9;
   localparam int CW_RF_W       = 8;
   localparam int CW_RAM_EN     = 7;
   localparam int CW_RAM_W      = 6;
   localparam int CW_PC_FS      = 4;
   localparam int CW_PC_IS      = 3;
   localparam int CW_STATUS_LD  = 2;
   localparam int CW_NEXT_STATE = 0;

   // Left-shift distance of the immediate: one immediate width per hw step.
   function automatic logic [31:0] shift_amount(input logic [1:0] hw,
                                                input int unsigned step);
      return step * 32'(hw);
   endfunction

   // First state after an accepted start. Foreign opcodes stay in IDLE.
   function automatic state_t first_state(input logic [7:0] op,
                                          input logic       range_err);
      state_t st;
      st = ST_IDLE;
      if (op == OP_MOVZ || op == OP_MOVN) begin
         st = range_err ? ST_ERR : ST_EXEC;
      end else if (op == OP_MOVK) begin
         st = range_err ? ST_ERR : ST_MASK;
      end
      return st;
   endfunction

endpackage

// File: rtl/mov_wide_kgen.sv
// -----------------------------------------------------------------------------
// mov_wide_kgen
// Combinational K-constant generator for the wide-move family.
//   i_imm              immediate field
//   i_hw               shift selector; shift = IMM_WIDTH * hw
//   i_invert_mask_mode 0: o_k = imm << shift (zero-extended)
//                      1: o_k = ~(ones(IMM_WIDTH) << shift), the MOVK keep-mask
//   o_k                DATA_WIDTH constant for the ALU B input
//   o_range_err        shift does not fit inside DATA_WIDTH
// -----------------------------------------------------------------------------
module mov_wide_kgen
   import mov_wide_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int IMM_WIDTH  = 16
) (
   input  logic [IMM_WIDTH-1:0]  i_imm,
   input  logic [1:0]            i_hw,
   input  logic                  i_invert_mask_mode,
   output logic [DATA_WIDTH-1:0] o_k,
   output logic                  o_range_err
);

   logic [31:0]           w_shamt;
   logic [DATA_WIDTH-1:0] w_imm_ext;
   logic [DATA_WIDTH-1:0] w_ones_ext;

   assign w_shamt     = shift_amount(i_hw, IMM_WIDTH);
   assign o_range_err = (w_shamt >= 32'(DATA_WIDTH));

   always_comb begin
      w_imm_ext                   = '0;
      w_imm_ext[IMM_WIDTH-1:0]    = i_imm;
      w_ones_ext                  = '0;
      w_ones_ext[IMM_WIDTH-1:0]   = '1;
   end

   // An out-of-range shift yields 0 rather than whatever the shifter wraps to.
   always_comb begin
      o_k = '0;
      if (!o_range_err) begin
         if (i_invert_mask_mode) begin
            o_k = ~(w_ones_ext << w_shamt);
         end else begin
            o_k = w_imm_ext << w_shamt;
         end
      end
   end

endmodule

// File: rtl/iw_decoder_mov_wide.sv
// -----------------------------------------------------------------------------
// iw_decoder_mov_wide
// Sequenced IW decoder for MOVZ / MOVN / MOVK. MOVZ and MOVN issue a single
// EXEC micro-op. MOVK is read-modify-write, so it issues MASK (Rd & keep-mask)
// and then EXEC (Rd | shifted imm). A shift that falls outside the datapath
// issues a single ERR cycle.
//   clock    system clock, rising edge
//   reset_n  asynchronous active-low reset
//   start    instruction valid, sampled only in IDLE
//   I        {op[8:0], hw[1:0], imm[15:0], Rd[4:0]}; op[8] (sf) is ignored
//   cw_IW    33-bit control word (layout in mov_wide_pkg)
//   k        ALU B constant
//   busy     any non-IDLE state
//   done     final cycle of an instruction (EXEC or ERR)
//   illegal  ERR state
// Outputs are decoded only from registered state, so an asynchronous reset
// clears them in the same cycle.
// -----------------------------------------------------------------------------
module iw_decoder_mov_wide
   import mov_wide_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int IMM_WIDTH  = 16,
   parameter int XZR_ADDR   = 31
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [31:0]           I,
   output logic [CW_WIDTH-1:0]   cw_IW,
   output logic [DATA_WIDTH-1:0] k,
   output logic                  busy,
   output logic                  done,
   output logic                  illegal
);

   state_t                r_state;
   mov_fields_t           r_instr;

   mov_fields_t           w_in;
   logic                  w_unused_sf;
   logic [1:0]            w_kgen_hw;
   logic [15:0]           w_kgen_imm;
   logic [DATA_WIDTH-1:0] w_k;
   logic                  w_range_err;
   logic [CW_WIDTH-1:0]   w_cw;

   assign w_in        = I[30:0];
   // sf chooses the architectural register width elsewhere; this decoder
   // treats 32- and 64-bit forms identically.
   assign w_unused_sf = I[31];

   // In IDLE the generator looks at the incoming word so its range flag can
   // steer the first transition. Otherwise it looks at the latched word.
   assign w_kgen_hw  = (r_state == ST_IDLE) ? w_in.hw  : r_instr.hw;
   assign w_kgen_imm = (r_state == ST_IDLE) ? w_in.imm : r_instr.imm;

   mov_wide_kgen #(
      .DATA_WIDTH (DATA_WIDTH),
      .IMM_WIDTH  (IMM_WIDTH)
   ) u_kgen (
      .i_imm              (IMM_WIDTH'(w_kgen_imm)),
      .i_hw               (w_kgen_hw),
      .i_invert_mask_mode (r_state == ST_MASK),
      .o_k                (w_k),
      .o_range_err        (w_range_err)
   );

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_instr <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_instr <= w_in;
                  r_state <= first_state(w_in.op, w_range_err);
               end
            end
            ST_MASK: r_state <= ST_EXEC;
            ST_EXEC: r_state <= ST_IDLE;
            ST_ERR:  r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      // NOTE: every output has a default before the case, so no path leaves
      // one unassigned and no latch is inferred.
      w_cw    = '0;
      k       = '0;
      busy    = 1'b0;
      done    = 1'b0;
      illegal = 1'b0;

      if (r_state != ST_IDLE) begin
         busy                      = 1'b1;
         w_cw[CW_ALU_EN]           = 1'b1;
         w_cw[CW_ALU_BS]           = 1'b1;
         w_cw[CW_RF_B_EN]          = 1'b0;
         w_cw[CW_RF_SB +: 5]       = 5'd0;
         w_cw[CW_RAM_EN]           = 1'b0;
         w_cw[CW_RAM_W]            = 1'b0;
         w_cw[CW_PC_IS]            = 1'b0;
         w_cw[CW_STATUS_LD]        = 1'b0;
      end

      case (r_state)
         ST_MASK: begin
            w_cw[CW_ALU_FS +: 5]     = FS_AND;
            w_cw[CW_RF_SA +: 5]      = r_instr.rd;
            w_cw[CW_RF_DA +: 5]      = r_instr.rd;
            w_cw[CW_RF_W]            = 1'b1;
            w_cw[CW_PC_FS +: 2]      = PC_HOLD;
            w_cw[CW_NEXT_STATE +: 2] = NS_CONT;
            k                        = w_k;
         end
         ST_EXEC: begin
            // MOVN inverts through the ALU (A | ~B with A = XZR), so K stays
            // the plain shifted immediate for all three opcodes.
            w_cw[CW_ALU_FS +: 5]     = (r_instr.op == OP_MOVN) ? FS_OR_NB : FS_OR;
            w_cw[CW_RF_SA +: 5]      = (r_instr.op == OP_MOVK) ? r_instr.rd
                                                               : 5'(XZR_ADDR);
            w_cw[CW_RF_DA +: 5]      = r_instr.rd;
            w_cw[CW_RF_W]            = 1'b1;
            w_cw[CW_PC_FS +: 2]      = PC_INC4;
            w_cw[CW_NEXT_STATE +: 2] = NS_DONE;
            k                        = w_k;
            done                     = 1'b1;
         end
         ST_ERR: begin
            w_cw[CW_ALU_EN] = 1'b0;
            done            = 1'b1;
            illegal         = 1'b1;
         end
         default: ;
      endcase
   end

   assign cw_IW = w_cw;

endmodule

// File: tb/tb_iw_decoder_mov_wide.sv
// -----------------------------------------------------------------------------
// tb_iw_decoder_mov_wide
// Drives a 64-bit and a 32-bit instance of the wide-move decoder. It checks
// every micro-op against values the bench computes from the instruction
// semantics. A register-file/ALU model replays the issued micro-ops, so the
// final register value can be compared with what MOVZ/MOVN/MOVK should leave.
// -----------------------------------------------------------------------------
module tb_iw_decoder_mov_wide;

   localparam logic [7:0] MOVZ = 8'hA5;
   localparam logic [7:0] MOVN = 8'h25;
   localparam logic [7:0] MOVK = 8'hE5;

   logic        clock;
   logic        reset_n;
   logic        start64, start32;
   logic [31:0] I64, I32;
   logic [32:0] cw64, cw32;
   logic [63:0] k64;
   logic [31:0] k32;
   logic        busy64, done64, ill64;
   logic        busy32, done32, ill32;

   logic [63:0] rf [0:31];
   int n_vec = 0;
   int n_bad = 0;

   iw_decoder_mov_wide #(.DATA_WIDTH(64), .IMM_WIDTH(16), .XZR_ADDR(31)) dut64 (
      .clock(clock), .reset_n(reset_n), .start(start64), .I(I64),
      .cw_IW(cw64), .k(k64), .busy(busy64), .done(done64), .illegal(ill64));

   iw_decoder_mov_wide #(.DATA_WIDTH(32), .IMM_WIDTH(16), .XZR_ADDR(31)) dut32 (
      .clock(clock), .reset_n(reset_n), .start(start32), .I(I32),
      .cw_IW(cw32), .k(k32), .busy(busy32), .done(done32), .illegal(ill32));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // imm * 2^(16*hw) inside a dw-bit datapath; 0 when the shift does not fit.
   function automatic logic [63:0] model_s(input logic [15:0] imm, input int hw, input int dw);
      int sh;
      logic [63:0] v;
      sh = 16 * hw;
      if (sh >= dw) return 64'd0;
      v = 64'(imm) << sh;
      if (dw == 32) v = v & 64'h0000_0000_FFFF_FFFF;
      return v;
   endfunction

   // Keep-mask for MOVK: every bit except the 16 being replaced.
   function automatic logic [63:0] model_mask(input int hw, input int dw);
      int sh;
      logic [63:0] v;
      sh = 16 * hw;
      if (sh >= dw) return 64'd0;
      v = ~(64'h0000_0000_0000_FFFF << sh);
      if (dw == 32) v = v & 64'h0000_0000_FFFF_FFFF;
      return v;
   endfunction

   // Control word assembled field by field in documented order.
   function automatic logic [32:0] exp_cw(input logic alu_en, input logic [4:0] fs,
                                          input logic [4:0] sa, input logic [4:0] da,
                                          input logic rf_w, input logic [1:0] pc,
                                          input logic [1:0] ns);
      return {1'b0, alu_en, 1'b1, fs, 1'b0, sa, 5'd0, da, rf_w, 1'b0, 1'b0, pc, 1'b0, 1'b0, ns};
   endfunction

   // Register file + ALU reacting to one issued micro-op.
   task automatic alu_step(input logic [32:0] cw, input logic [63:0] kk);
      logic [4:0]  sa, da;
      logic [63:0] a, res;
      sa  = cw[23:19];
      da  = cw[13:9];
      a   = (sa == 5'd31) ? 64'd0 : rf[sa];
      case (cw[29:25])
         5'b00000: res = a & kk;
         5'b00100: res = a | kk;
         5'b00110: res = a | ~kk;
         default:  res = 64'hDEAD_DEAD_DEAD_DEAD;
      endcase
      if (cw[31] && cw[8] && da != 5'd31) rf[da] = res;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [7:0] op;
      case ($urandom_range(0, 3))
         0: op = MOVZ;
         1: op = MOVN;
         2: op = MOVK;
         default: begin
            op = 8'($urandom);
            if (op == MOVZ || op == MOVN || op == MOVK) op = op ^ 8'h01;
         end
      endcase
      return {1'($urandom), op, 2'($urandom), 16'($urandom), 5'($urandom)};
   endfunction

   // One instruction on the 64-bit instance; entered and left at a negedge in IDLE.
   task automatic run64(input logic [31:0] instr, input bit poke);
      logic [7:0]  op;
      logic [1:0]  hw;
      logic [15:0] imm;
      logic [4:0]  rd;
      logic [63:0] s, old, want;
      op  = instr[30:23];
      hw  = instr[22:21];
      imm = instr[20:5];
      rd  = instr[4:0];
      s   = model_s(imm, int'(hw), 64);
      old = rf[rd];
      start64 = 1'b1;
      I64     = instr;
      @(negedge clock);
      start64 = 1'b0;
      I64     = $urandom;
      if (op == MOVK) begin
         check("movk_mask_cw", 64'(cw64), 64'(exp_cw(1'b1, 5'b00000, rd, rd, 1'b1, 2'b00, 2'b01)));
         check("movk_mask_k", k64, model_mask(int'(hw), 64));
         check("movk_mask_done", 64'(done64), 64'd0);
         check("movk_mask_busy", 64'(busy64), 64'd1);
         alu_step(cw64, k64);
         if (poke) begin
            start64 = 1'b1;
            I64     = {1'b1, MOVZ, 2'b00, 16'hFFFF, 5'd0};
         end
         @(negedge clock);
         start64 = 1'b0;
         check("movk_exec_cw", 64'(cw64), 64'(exp_cw(1'b1, 5'b00100, rd, rd, 1'b1, 2'b01, 2'b00)));
         check("movk_exec_k", k64, s);
         check("movk_exec_done", 64'(done64), 64'd1);
         check("movk_exec_ill", 64'(ill64), 64'd0);
         alu_step(cw64, k64);
         want = (old & model_mask(int'(hw), 64)) | s;
      end else if (op == MOVZ || op == MOVN) begin
         check("mov_exec_cw", 64'(cw64),
               64'(exp_cw(1'b1, (op == MOVN) ? 5'b00110 : 5'b00100, 5'd31, rd, 1'b1, 2'b01, 2'b00)));
         check("mov_exec_k", k64, s);
         check("mov_exec_done", 64'(done64), 64'd1);
         check("mov_exec_busy", 64'(busy64), 64'd1);
         alu_step(cw64, k64);
         want = (op == MOVN) ? ~s : s;
      end else begin
         check("foreign_cw", 64'(cw64), 64'd0);
         check("foreign_busy", 64'(busy64), 64'd0);
         check("foreign_k", k64, 64'd0);
         return;
      end
      @(negedge clock);
      check("after_busy", 64'(busy64), 64'd0);
      check("after_cw", 64'(cw64), 64'd0);
      check("after_done", 64'(done64), 64'd0);
      if (rd != 5'd31) check("rf_result", rf[rd], want);
   endtask

   // One instruction on the 32-bit instance (micro-op level only).
   task automatic run32(input logic [31:0] instr);
      logic [7:0]  op;
      logic [1:0]  hw;
      logic [4:0]  rd;
      logic [63:0] s;
      bit          mine, bad;
      op   = instr[30:23];
      hw   = instr[22:21];
      rd   = instr[4:0];
      s    = model_s(instr[20:5], int'(hw), 32);
      mine = (op == MOVZ || op == MOVN || op == MOVK);
      bad  = mine && (16 * int'(hw) >= 32);
      start32 = 1'b1;
      I32     = instr;
      @(negedge clock);
      start32 = 1'b0;
      if (!mine) begin
         check("w32_foreign_cw", 64'(cw32), 64'd0);
         check("w32_foreign_busy", 64'(busy32), 64'd0);
         check("w32_foreign_ill", 64'(ill32), 64'd0);
         return;
      end
      if (bad) begin
         check("w32_err_ill", 64'(ill32), 64'd1);
         check("w32_err_done", 64'(done32), 64'd1);
         check("w32_err_alu_en", 64'(cw32[31]), 64'd0);
         check("w32_err_rf_w", 64'(cw32[8]), 64'd0);
         check("w32_err_pc_fs", 64'(cw32[5:4]), 64'd0);
         check("w32_err_k", 64'(k32), 64'd0);
      end else begin
         if (op == MOVK) begin
            check("w32_mask_cw", 64'(cw32), 64'(exp_cw(1'b1, 5'b00000, rd, rd, 1'b1, 2'b00, 2'b01)));
            check("w32_mask_k", 64'(k32), model_mask(int'(hw), 32));
            @(negedge clock);
         end
         check("w32_exec_cw", 64'(cw32),
               64'(exp_cw(1'b1, (op == MOVN) ? 5'b00110 : 5'b00100,
                          (op == MOVK) ? rd : 5'd31, rd, 1'b1, 2'b01, 2'b00)));
         check("w32_exec_k", 64'(k32), s);
         check("w32_exec_done", 64'(done32), 64'd1);
         check("w32_exec_ill", 64'(ill32), 64'd0);
      end
      @(negedge clock);
      check("w32_after_busy", 64'(busy32), 64'd0);
      check("w32_after_ill", 64'(ill32), 64'd0);
      check("w32_after_cw", 64'(cw32), 64'd0);
   endtask

   initial begin
      reset_n = 1'b0;
      start64 = 1'b0;
      start32 = 1'b0;
      I64     = '0;
      I32     = '0;
      for (int i = 0; i < 32; i++) rf[i] = {$urandom, $urandom};

      @(negedge clock);
      @(negedge clock);
      check("rst_cw64", 64'(cw64), 64'd0);
      check("rst_k64", k64, 64'd0);
      check("rst_busy64", 64'(busy64), 64'd0);
      check("rst_done64", 64'(done64), 64'd0);
      check("rst_ill64", 64'(ill64), 64'd0);
      check("rst_cw32", 64'(cw32), 64'd0);
      reset_n = 1'b1;
      @(negedge clock);
      check("idle_busy64", 64'(busy64), 64'd0);

      // Directed cases from the worked examples.
      run64({1'b1, MOVZ, 2'b01, 16'h1234, 5'd3}, 1'b0);
      check("movz_x3", rf[3], 64'h0000_0000_1234_0000);
      rf[5] = 64'h1111_2222_3333_4444;
      run64({1'b1, MOVK, 2'b11, 16'hBEEF, 5'd5}, 1'b1);
      check("movk_x5", rf[5], 64'hBEEF_2222_3333_4444);
      run64({1'b1, MOVN, 2'b00, 16'h0000, 5'd1}, 1'b0);
      check("movn_x1", rf[1], 64'hFFFF_FFFF_FFFF_FFFF);

      run32({1'b0, MOVZ, 2'b10, 16'hABCD, 5'd7});
      run32({1'b0, MOVZ, 2'b01, 16'hABCD, 5'd7});
      run32({1'b0, MOVK, 2'b11, 16'h5555, 5'd2});
      run32({1'b0, MOVK, 2'b01, 16'h1357, 5'd2});
      run32({1'b0, 8'h00, 2'b11, 16'hFFFF, 5'd9});

      // Asynchronous reset while MOVK sits in its mask step.
      start64 = 1'b1;
      I64     = {1'b1, MOVK, 2'b01, 16'h4242, 5'd6};
      @(negedge clock);
      start64 = 1'b0;
      check("rstmid_in_mask", 64'(busy64), 64'd1);
      reset_n = 1'b0;
      #1;
      check("rstmid_cw", 64'(cw64), 64'd0);
      check("rstmid_busy", 64'(busy64), 64'd0);
      check("rstmid_k", k64, 64'd0);
      @(negedge clock);
      reset_n = 1'b1;
      check("rstmid_release_busy", 64'(busy64), 64'd0);
      @(negedge clock);
      check("rstmid_no_exec_busy", 64'(busy64), 64'd0);
      check("rstmid_no_exec_cw", 64'(cw64), 64'd0);

      // Randomised back-to-back traffic.
      for (int i = 0; i < 30; i++) run64(rand_instr(), 1'($urandom_range(0, 1)));
      for (int i = 0; i < 16; i++) run32(rand_instr());

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
